// File: rtl/prog_loader.sv
// Program-memory loader: assembles host nibbles (high first) into bytes and writes them from address 0.
// Optional running checksum enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
   parameter int ADDR_W = 12
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_start,
   input  logic              load_end,
   input  logic [3:0]        nib_in,
   input  logic              nib_valid,
   output logic              nib_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   byte_count,
   output logic [7:0]        checksum
);

   typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [7:0]          wr_data_q, wr_data_d;
   logic [ADDR_W:0]     byte_count_q, byte_count_d;
   logic                err_q, err_d;
   logic                wr_en_q, wr_en_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // nib_ready must not depend on nib_valid, so the host can wait on it safely
   assign nib_ready = ((state_q == HI) || (state_q == LO)) && !load_end;

   always_comb begin
      state_d      = state_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      byte_count_d = byte_count_q;
      err_d        = err_q;
      case (state_q)
         IDLE: begin
            if (load_start) begin
               state_d      = HI;
               wr_addr_d    = '0;
               byte_count_d = '0;
               err_d        = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         HI: begin
            if (load_end) begin
               state_d = DONE;
            end else if (nib_valid) begin
               wr_data_d[7:4] = nib_in;
               state_d        = LO;
            end else begin
               state_d = HI;
            end
         end
         LO: begin
            if (load_end) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else if (nib_valid) begin
               wr_data_d[3:0] = nib_in;
               state_d        = WRITE;
            end else begin
               state_d = LO;
            end
         end
         WRITE: begin
            wr_addr_d    = wr_addr_q + 1'b1;
            byte_count_d = byte_count_q + 1'b1;
            // the last address ends the load without waiting for load_end
            if (wr_addr_q == {ADDR_W{1'b1}}) begin
               state_d = DONE;
            end else begin
               state_d = HI;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d  = (state_d != IDLE);
      wr_en_d = (state_d == WRITE);
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         wr_addr_q    <= '0;
         wr_data_q    <= 8'h00;
         byte_count_q <= '0;
         err_q        <= 1'b0;
         wr_en_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         byte_count_q <= byte_count_d;
         err_q        <= err_d;
         wr_en_q      <= wr_en_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign byte_count = byte_count_q;
   assign err        = err_q;
   assign busy       = busy_q;
   assign cpu_hold   = busy_q;
   assign done       = done_q;

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if ((state_q == IDLE) && load_start) begin
         checksum_d = 8'h00;
      end else if (state_q == WRITE) begin
         checksum_d = checksum_q + wr_data_q;
      end else begin
         checksum_d = checksum_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         checksum_q <= 8'h00;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Table-driven bench for prog_loader plus hand sequences for full-depth load and mid-load reset.
module tb_prog_loader;

   logic        clock = 1'b0;
   logic        reset;
   logic        load_start, load_end, nib_valid;
   logic [3:0]  nib_in;
   logic        nib_ready, wr_en, cpu_hold, busy, done, err;
   logic [11:0] wr_addr;
   logic [7:0]  wr_data, checksum;
   logic [12:0] byte_count;

   int n_cmp  = 0;
   int n_fail = 0;

`ifdef PROG_LOADER_CHECKSUM_EN
   localparam bit CKS_EN = 1'b1;
`else
   localparam bit CKS_EN = 1'b0;
`endif

   prog_loader #(.ADDR_W(12)) dut (
      .clock(clock), .reset(reset), .load_start(load_start), .load_end(load_end),
      .nib_in(nib_in), .nib_valid(nib_valid), .nib_ready(nib_ready), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold), .busy(busy),
      .done(done), .err(err), .byte_count(byte_count), .checksum(checksum)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        ls;
      logic        le;
      logic [3:0]  nib;
      logic        nv;
      logic        rdy;
      logic        wen;
      logic [11:0] addr;
      logic [7:0]  data;
      logic        busy;
      logic        done;
      logic        err;
      logic [12:0] bc;
      logic [7:0]  cks;
   } vec_t;

   vec_t tbl [37];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_cks(input logic [7:0] sum);
      return CKS_EN ? sum : 8'h00;
   endfunction

   task automatic drive(input logic ls, input logic le, input logic [3:0] nib, input logic nv);
      load_start = ls;
      load_end   = le;
      nib_in     = nib;
      nib_valid  = nv;
   endtask

   initial begin
      int          wcnt;
      int          ncyc;
      logic [11:0] last_addr;
      bit          seen_done;

      drive(1'b0, 1'b0, 4'h0, 1'b0);
      reset = 1'b1;
      #12;
      chk("reset_busy", -1, {31'd0, busy}, 32'd0);
      chk("reset_hold", -1, {31'd0, cpu_hold}, 32'd0);
      chk("reset_wr_en", -1, {31'd0, wr_en}, 32'd0);
      chk("reset_ready", -1, {31'd0, nib_ready}, 32'd0);
      chk("reset_addr", -1, {20'd0, wr_addr}, 32'd0);
      chk("reset_bc", -1, {19'd0, byte_count}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      //        ls    le    nib   nv    rdy   wen   addr    data   busy  done  err   bc      cks
      tbl[0]  = {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'd0, 8'h00, 1'b1, 1'b0, 1'b0, 13'd0, 8'h00};
      tbl[1]  = {1'b0, 1'b0, 4'h4, 1'b1, 1'b1, 1'b0, 12'd0, 8'h40, 1'b1, 1'b0, 1'b0, 13'd0, 8'h00};
      tbl[2]  = {1'b0, 1'b0, 4'h1, 1'b1, 1'b1, 1'b1, 12'd0, 8'h41, 1'b1, 1'b0, 1'b0, 13'd0, 8'h00};
      tbl[3]  = {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'd1, 8'h41, 1'b1, 1'b0, 1'b0, 13'd1, 8'h41};
      tbl[4]  = {1'b0, 1'b0, 4'hA, 1'b1, 1'b1, 1'b0, 12'd1, 8'hA1, 1'b1, 1'b0, 1'b0, 13'd1, 8'h41};
      tbl[5]  = {1'b0, 1'b0, 4'h3, 1'b1, 1'b1, 1'b1, 12'd1, 8'hA3, 1'b1, 1'b0, 1'b0, 13'd1, 8'h41};
      tbl[6]  = {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'd2, 8'hA3, 1'b1, 1'b0, 1'b0, 13'd2, 8'hE4};
      tbl[7]  = {1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 12'd2, 8'hA3, 1'b1, 1'b1, 1'b0, 13'd2, 8'hE4};
      tbl[8]  = {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'd2, 8'hA3, 1'b0, 1'b0, 1'b0, 13'd2, 8'hE4};
      // odd nibble count ends in LO with err
      tbl[9]  = {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'd0, 8'hA3, 1'b1, 1'b0, 1'b0, 13'd0, 8'h00};
      tbl[10] = {1'b0, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 12'd0, 8'h53, 1'b1, 1'b0, 1'b0, 13'd0, 8'h00};
      tbl[11] = {1'b0, 1'b0, 4'h2, 1'b1, 1'b1, 1'b1, 12'd0, 8'h52, 1'b1, 1'b0, 1'b0, 13'd0, 8'h00};
      tbl[12] = {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'd1, 8'h52, 1'b1, 1'b0, 1'b0, 13'd1, 8'h52};
      tbl[13] = {1'b0, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0, 12'd1, 8'h72, 1'b1, 1'b0, 1'b0, 13'd1, 8'h52};
      tbl[14] = {1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 12'd1, 8'h72, 1'b0, 1'b0, 1'b1, 13'd1, 8'h52};
      tbl[15] = {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'd1, 8'h72, 1'b0, 1'b0, 1'b1, 13'd1, 8'h52};
      // load_start clears err; then gaps and load_end colliding with nib_valid in HI
      tbl[16] = {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'd0, 8'h72, 1'b1, 1'b0, 1'b0, 13'd0, 8'h00};
      tbl[17] = {1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 12'd0, 8'h72, 1'b1, 1'b0, 1'b0, 13'd0, 8'h00};
      tbl[18] = {1'b0, 1'b0, 4'hC, 1'b1, 1'b1, 1'b0, 12'd0, 8'hC2, 1'b1, 1'b0, 1'b0, 13'd0, 8'h00};
      tbl[19] = {1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 12'd0, 8'hC2, 1'b1, 1'b0, 1'b0, 13'd0, 8'h00};
      tbl[20] = {1'b0, 1'b0, 4'hD, 1'b1, 1'b1, 1'b1, 12'd0, 8'hCD, 1'b1, 1'b0, 1'b0, 13'd0, 8'h00};
      tbl[21] = {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'd1, 8'hCD, 1'b1, 1'b0, 1'b0, 13'd1, 8'hCD};
      tbl[22] = {1'b0, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 12'd1, 8'hCD, 1'b1, 1'b1, 1'b0, 13'd1, 8'hCD};
      tbl[23] = {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'd1, 8'hCD, 1'b0, 1'b0, 1'b0, 13'd1, 8'hCD};
      // checksum 10+20+F5, load_end in WRITE and load_start in HI ignored
      tbl[24] = {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'd0, 8'hCD, 1'b1, 1'b0, 1'b0, 13'd0, 8'h00};
      tbl[25] = {1'b0, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 12'd0, 8'h1D, 1'b1, 1'b0, 1'b0, 13'd0, 8'h00};
      tbl[26] = {1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 12'd0, 8'h10, 1'b1, 1'b0, 1'b0, 13'd0, 8'h00};
      tbl[27] = {1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 12'd1, 8'h10, 1'b1, 1'b0, 1'b0, 13'd1, 8'h10};
      tbl[28] = {1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 12'd1, 8'h10, 1'b1, 1'b0, 1'b0, 13'd1, 8'h10};
      tbl[29] = {1'b0, 1'b0, 4'h2, 1'b1, 1'b1, 1'b0, 12'd1, 8'h20, 1'b1, 1'b0, 1'b0, 13'd1, 8'h10};
      tbl[30] = {1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 12'd1, 8'h20, 1'b1, 1'b0, 1'b0, 13'd1, 8'h10};
      tbl[31] = {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'd2, 8'h20, 1'b1, 1'b0, 1'b0, 13'd2, 8'h30};
      tbl[32] = {1'b0, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 12'd2, 8'hF0, 1'b1, 1'b0, 1'b0, 13'd2, 8'h30};
      tbl[33] = {1'b0, 1'b0, 4'h5, 1'b1, 1'b1, 1'b1, 12'd2, 8'hF5, 1'b1, 1'b0, 1'b0, 13'd2, 8'h30};
      tbl[34] = {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'd3, 8'hF5, 1'b1, 1'b0, 1'b0, 13'd3, 8'h25};
      tbl[35] = {1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 12'd3, 8'hF5, 1'b1, 1'b1, 1'b0, 13'd3, 8'h25};
      tbl[36] = {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'd3, 8'hF5, 1'b0, 1'b0, 1'b0, 13'd3, 8'h25};

      for (int i = 0; i < 37; i++) begin
         drive(tbl[i].ls, tbl[i].le, tbl[i].nib, tbl[i].nv);
         #1;
         chk("nib_ready", i, {31'd0, nib_ready}, {31'd0, tbl[i].rdy});
         @(posedge clock); #1;
         chk("wr_en", i, {31'd0, wr_en}, {31'd0, tbl[i].wen});
         chk("wr_addr", i, {20'd0, wr_addr}, {20'd0, tbl[i].addr});
         chk("wr_data", i, {24'd0, wr_data}, {24'd0, tbl[i].data});
         chk("busy", i, {31'd0, busy}, {31'd0, tbl[i].busy});
         chk("cpu_hold", i, {31'd0, cpu_hold}, {31'd0, tbl[i].busy});
         chk("done", i, {31'd0, done}, {31'd0, tbl[i].done});
         chk("err", i, {31'd0, err}, {31'd0, tbl[i].err});
         chk("byte_count", i, {19'd0, byte_count}, {19'd0, tbl[i].bc});
         chk("checksum", i, {24'd0, checksum}, {24'd0, exp_cks(tbl[i].cks)});
      end

      // full-depth load of 0xFF bytes, ends without load_end
      drive(1'b1, 1'b0, 4'hF, 1'b1);
      @(posedge clock); #1;
      drive(1'b0, 1'b0, 4'hF, 1'b1);
      wcnt = 0; ncyc = 0; last_addr = 12'd0; seen_done = 1'b0;
      for (int c = 0; c < 20000 && !seen_done; c++) begin
         @(posedge clock); #1;
         ncyc++;
         if (wr_en) begin
            wcnt++;
            last_addr = wr_addr;
         end
         if (done) seen_done = 1'b1;
      end
      chk("full_done_seen", 100, {31'd0, seen_done}, 32'd1);
      chk("full_cycles", 100, ncyc, 32'd12288);
      chk("full_writes", 100, wcnt, 32'd4096);
      chk("full_last_addr", 100, {20'd0, last_addr}, 32'd4095);
      chk("full_byte_count", 100, {19'd0, byte_count}, 32'd4096);
      chk("full_wr_addr", 100, {20'd0, wr_addr}, 32'd0);
      chk("full_checksum", 100, {24'd0, checksum}, 32'd0);
      chk("full_hold_at_done", 100, {31'd0, cpu_hold}, 32'd1);
      drive(1'b0, 1'b0, 4'h0, 1'b0);
      @(posedge clock); #1;
      chk("full_hold_after", 101, {31'd0, cpu_hold}, 32'd0);
      chk("full_err", 101, {31'd0, err}, 32'd0);

      // reset asserted mid-cycle while waiting for a low nibble
      drive(1'b1, 1'b0, 4'h0, 1'b0); @(posedge clock); #1;
      drive(1'b0, 1'b0, 4'h6, 1'b1); @(posedge clock); #1;
      drive(1'b0, 1'b0, 4'h7, 1'b1); @(posedge clock); #1;
      drive(1'b0, 1'b0, 4'h0, 1'b0); @(posedge clock); #1;
      drive(1'b0, 1'b0, 4'h8, 1'b1); @(posedge clock); #1;
      drive(1'b0, 1'b0, 4'h9, 1'b0);
      chk("pre_rst_bc", 200, {19'd0, byte_count}, 32'd1);
      chk("pre_rst_data", 200, {24'd0, wr_data}, 32'h87);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_busy", 201, {31'd0, busy}, 32'd0);
      chk("rst_hold", 201, {31'd0, cpu_hold}, 32'd0);
      chk("rst_ready", 201, {31'd0, nib_ready}, 32'd0);
      chk("rst_wr_en", 201, {31'd0, wr_en}, 32'd0);
      chk("rst_addr", 201, {20'd0, wr_addr}, 32'd0);
      chk("rst_data", 201, {24'd0, wr_data}, 32'd0);
      chk("rst_bc", 201, {19'd0, byte_count}, 32'd0);
      chk("rst_done_err", 201, {30'd0, done, err}, 32'd0);
      chk("rst_checksum", 201, {24'd0, checksum}, 32'd0);
      drive(1'b0, 1'b0, 4'h9, 1'b1);
      @(posedge clock); #1;
      chk("rst_no_write", 202, {31'd0, wr_en}, 32'd0);
      reset = 1'b0;
      drive(1'b0, 1'b0, 4'h0, 1'b0);
      @(posedge clock); #1;
      chk("rst_idle", 203, {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
